// File: rtl/roi_pkg.sv
`default_nettype none
// ============================================================================
// roi_pkg : register map, field positions and shared types for roi_apb_multi
// Revision : 1.0  initial release
// ============================================================================
package roi_pkg;

  localparam int CTRL_OFS   = 'h000;
  localparam int STATUS_OFS = 'h004;
  localparam int XY_BASE    = 'h010;
  localparam int XY_STRIDE  = 8;
  localparam int XY1_OFS    = 4;

  localparam int COMMIT_BIT = 0;
  localparam int EN_LSB     = 8;
  localparam int PEND_BIT   = 0;
  localparam int ERR_BIT    = 1;
  localparam int IRQ_BIT    = 2;
  localparam int X_LSB      = 16;
  localparam int Y_LSB      = 0;
  localparam int COORD_MAX_W = 16;

  typedef struct packed {
    logic [COORD_MAX_W-1:0] x;
    logic [COORD_MAX_W-1:0] y;
  } roi_coord_t;

  typedef struct packed {
    roi_coord_t p0;
    roi_coord_t p1;
    logic       en;
  } roi_rect_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // Pad bits above COORD_W are dropped so shadows never hold stray high bits.
  function automatic roi_coord_t coord_unpack(input logic [31:0] d, input int unsigned w);
    roi_coord_t      c;
    logic [15:0]     m;
    m   = 16'hFFFF >> (16 - w);
    c.x = d[X_LSB +: 16] & m;
    c.y = d[Y_LSB +: 16] & m;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/roi_apb_multi_if.sv
`default_nettype none
// ============================================================================
// roi_apb_multi_if : APB3 bus bundle with master/slave views
// Revision : 1.0  initial release
// ============================================================================
interface roi_apb_multi_if #(
  parameter int APB_DATA_W = 32,
  parameter int APB_ADDR_W = 12
);
  logic [APB_ADDR_W-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/roi_slot.sv
`default_nettype none
// ============================================================================
// roi_slot : one region - shadow rectangle, active copy and corner validation
// Revision : 1.0  initial release
// ============================================================================
module roi_slot
  import roi_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               wr_xy0_i,
  input  logic               wr_xy1_i,
  input  logic               wr_en_i,
  input  logic               en_wdata_i,
  input  roi_coord_t         coord_i,
  input  logic               apply_i,
  output roi_rect_t          shadow_o,
  output logic               invalid_o,
  output logic               act_en_o,
  output logic [COORD_W-1:0] act_x0_o,
  output logic [COORD_W-1:0] act_y0_o,
  output logic [COORD_W-1:0] act_x1_o,
  output logic [COORD_W-1:0] act_y1_o
);

  roi_rect_t          r_shadow;
  logic               r_act_en;
  logic [COORD_W-1:0] r_act_x0, r_act_y0, r_act_x1, r_act_y1;

  assign invalid_o = (r_shadow.p0.x > r_shadow.p1.x) || (r_shadow.p0.y > r_shadow.p1.y);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_shadow <= '0;
    end else begin
      if (wr_xy0_i) r_shadow.p0 <= coord_i;
      if (wr_xy1_i) r_shadow.p1 <= coord_i;
      if (wr_en_i)  r_shadow.en <= en_wdata_i;
    end
  end

  // Inverted corners are still copied so software can read what was applied.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_act_en <= 1'b0;
      r_act_x0 <= '0;
      r_act_y0 <= '0;
      r_act_x1 <= '0;
      r_act_y1 <= '0;
    end else if (apply_i) begin
      r_act_en <= r_shadow.en & ~invalid_o;
      r_act_x0 <= r_shadow.p0.x[COORD_W-1:0];
      r_act_y0 <= r_shadow.p0.y[COORD_W-1:0];
      r_act_x1 <= r_shadow.p1.x[COORD_W-1:0];
      r_act_y1 <= r_shadow.p1.y[COORD_W-1:0];
    end
  end

  assign shadow_o = r_shadow;
  assign act_en_o = r_act_en;
  assign act_x0_o = r_act_x0;
  assign act_y0_o = r_act_y0;
  assign act_x1_o = r_act_x1;
  assign act_y1_o = r_act_y1;

endmodule
`default_nettype wire

// File: rtl/roi_apb_multi.sv
`default_nettype none
// ============================================================================
// roi_apb_multi : APB slave with ROI_NUM regions, frame-synchronous commit
//                 Optional ROI_IRQ_EN adds irq_o and STATUS bit2.
// Revision : 1.0  initial release
// ============================================================================
module roi_apb_multi
  import roi_pkg::*;
#(
  parameter int APB_DATA_W = 32,
  parameter int APB_ADDR_W = 12,
  parameter int ROI_NUM    = 4,
  parameter int COORD_W    = 10,
  parameter int WAIT_ST    = 0
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  roi_apb_multi_if.slave             apb,
  input  logic                       frame_start_i,
  output logic [ROI_NUM-1:0]         roi_en_o,
  output logic [ROI_NUM*COORD_W-1:0] roi_x0_o,
  output logic [ROI_NUM*COORD_W-1:0] roi_y0_o,
  output logic [ROI_NUM*COORD_W-1:0] roi_x1_o,
  output logic [ROI_NUM*COORD_W-1:0] roi_y1_o,
  output logic                       commit_done_o
`ifdef ROI_IRQ_EN
  ,
  output logic                       irq_o
`endif
);

  localparam int C_WORD_W = APB_ADDR_W - 2;

  apb_state_t            r_state;
  logic [2:0]            r_wait_cnt;
  logic                  r_pending;
  logic                  r_err;
  logic                  r_commit_done;
  logic                  w_irq_rd;

  logic [C_WORD_W-1:0]   w_word;
  logic                  w_is_ctrl, w_is_stat, w_is_xy, w_mapped;
  logic [ROI_NUM-1:0]    w_hit0, w_hit1, w_invalid;
  logic                  w_pready, w_err, w_wr_ok, w_apply;
  roi_coord_t            w_coord;
  roi_rect_t             w_shadow [ROI_NUM];
  logic [APB_DATA_W-1:0] w_rdata;

  assign w_word    = apb.paddr[APB_ADDR_W-1:2];
  assign w_is_ctrl = (w_word == C_WORD_W'(CTRL_OFS / 4));
  assign w_is_stat = (w_word == C_WORD_W'(STATUS_OFS / 4));
  assign w_is_xy   = |{w_hit0, w_hit1};
  assign w_mapped  = w_is_ctrl | w_is_stat | w_is_xy;
  assign w_coord   = coord_unpack(apb.pwdata, COORD_W);

  // ------------------------------------------------------------------ APB FSM
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 3'd0;
    end else if (apb.psel && !apb.penable) begin
      r_wait_cnt <= 3'(WAIT_ST);
      r_state    <= (WAIT_ST == 0) ? ST_ACCESS : ST_WAIT;
    end else if (!apb.psel) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 3'd0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_wait_cnt <= 3'd1) begin
            r_wait_cnt <= 3'd0;
            r_state    <= ST_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_pready = (r_state == ST_ACCESS) && apb.psel && apb.penable;

  // Writes are refused while a commit is outstanding so the snapshot stays coherent.
  assign w_err   = !w_mapped
                 || (apb.pwrite && w_is_stat && apb.pwdata[PEND_BIT])
                 || (apb.pwrite && r_pending && (w_is_ctrl || w_is_xy));
  assign w_wr_ok = w_pready && apb.pwrite && !w_err;
  assign w_apply = frame_start_i && r_pending;

  // ------------------------------------------------------------------ slots
  for (genvar i = 0; i < ROI_NUM; i++) begin : g_slot
    assign w_hit0[i] = (w_word == C_WORD_W'((XY_BASE + i * XY_STRIDE) / 4));
    assign w_hit1[i] = (w_word == C_WORD_W'((XY_BASE + i * XY_STRIDE + XY1_OFS) / 4));

    roi_slot #(.COORD_W(COORD_W)) u_slot (
      .clk_i      (clk_i),
      .arst_i     (arst_i),
      .wr_xy0_i   (w_wr_ok && w_hit0[i]),
      .wr_xy1_i   (w_wr_ok && w_hit1[i]),
      .wr_en_i    (w_wr_ok && w_is_ctrl),
      .en_wdata_i (apb.pwdata[EN_LSB + i]),
      .coord_i    (w_coord),
      .apply_i    (w_apply),
      .shadow_o   (w_shadow[i]),
      .invalid_o  (w_invalid[i]),
      .act_en_o   (roi_en_o[i]),
      .act_x0_o   (roi_x0_o[i*COORD_W +: COORD_W]),
      .act_y0_o   (roi_y0_o[i*COORD_W +: COORD_W]),
      .act_x1_o   (roi_x1_o[i*COORD_W +: COORD_W]),
      .act_y1_o   (roi_y1_o[i*COORD_W +: COORD_W])
    );
  end

  // ------------------------------------------------------------------ CTRL/STATUS
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_pending     <= 1'b0;
      r_err         <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_commit_done <= w_apply;
      if (w_apply)
        r_pending <= 1'b0;
      else if (w_wr_ok && w_is_ctrl && apb.pwdata[COMMIT_BIT])
        r_pending <= 1'b1;
      if (w_apply && (|w_invalid))
        r_err <= 1'b1;
      else if (w_wr_ok && w_is_stat && apb.pwdata[ERR_BIT])
        r_err <= 1'b0;
    end
  end

`ifdef ROI_IRQ_EN
  logic r_irq;
  logic r_err_d;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_irq   <= 1'b0;
      r_err_d <= 1'b0;
    end else begin
      r_err_d <= r_err;
      if (r_commit_done || (r_err && !r_err_d))
        r_irq <= 1'b1;
      else if (w_wr_ok && w_is_stat && apb.pwdata[IRQ_BIT])
        r_irq <= 1'b0;
    end
  end

  assign w_irq_rd = r_irq;
  assign irq_o    = r_irq;
`else
  assign w_irq_rd = 1'b0;
`endif

  // ------------------------------------------------------------------ read mux
  always_comb begin
    w_rdata = '0;
    if (w_is_ctrl) begin
      w_rdata[COMMIT_BIT] = r_pending;
      for (int i = 0; i < ROI_NUM; i++)
        w_rdata[EN_LSB + i] = w_shadow[i].en;
    end else if (w_is_stat) begin
      w_rdata[PEND_BIT] = r_pending;
      w_rdata[ERR_BIT]  = r_err;
      w_rdata[IRQ_BIT]  = w_irq_rd;
    end else begin
      for (int i = 0; i < ROI_NUM; i++) begin
        if (w_hit0[i]) w_rdata = {w_shadow[i].p0.x, w_shadow[i].p0.y};
        if (w_hit1[i]) w_rdata = {w_shadow[i].p1.x, w_shadow[i].p1.y};
      end
    end
  end

  assign apb.pready    = w_pready;
  assign apb.pslverr   = w_pready && w_err;
  assign apb.prdata    = (w_pready && !apb.pwrite) ? w_rdata : '0;
  assign commit_done_o = r_commit_done;

endmodule
`default_nettype wire

// File: tb/tb_roi_apb_multi.sv
`default_nettype none
// ============================================================================
// tb_roi_apb_multi : directed bench for roi_apb_multi (zero-wait and WAIT_ST=3)
// Revision : 1.0  initial release
// ============================================================================
module tb_roi_apb_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame = 1'b0;
  logic        use3 = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;

  int nvec = 0;
  int errs = 0;

`ifdef ROI_IRQ_EN
  localparam logic [31:0] C_IRQ = 32'h4;
  logic irq0, irq3;
`else
  localparam logic [31:0] C_IRQ = 32'h0;
`endif

  roi_apb_multi_if #(.APB_DATA_W(32), .APB_ADDR_W(12)) bus0 ();
  roi_apb_multi_if #(.APB_DATA_W(32), .APB_ADDR_W(12)) bus3 ();

  assign bus0.psel = psel & ~use3;  assign bus3.psel = psel & use3;
  assign bus0.penable = penable;    assign bus3.penable = penable;
  assign bus0.pwrite = pwrite;      assign bus3.pwrite = pwrite;
  assign bus0.paddr = paddr;        assign bus3.paddr = paddr;
  assign bus0.pwdata = pwdata;      assign bus3.pwdata = pwdata;

  logic        cur_pready, cur_pslverr;
  logic [31:0] cur_prdata;
  assign cur_pready  = use3 ? bus3.pready  : bus0.pready;
  assign cur_pslverr = use3 ? bus3.pslverr : bus0.pslverr;
  assign cur_prdata  = use3 ? bus3.prdata  : bus0.prdata;

  logic [3:0]  en0, en3;
  logic [39:0] x0_0, y0_0, x1_0, y1_0, x0_3, y0_3, x1_3, y1_3;
  logic        cd0, cd3;

  roi_apb_multi #(.ROI_NUM(4), .COORD_W(10), .WAIT_ST(0)) dut0 (
    .clk_i(clk), .arst_i(rst), .apb(bus0), .frame_start_i(frame),
    .roi_en_o(en0), .roi_x0_o(x0_0), .roi_y0_o(y0_0), .roi_x1_o(x1_0), .roi_y1_o(y1_0),
    .commit_done_o(cd0)
`ifdef ROI_IRQ_EN
    , .irq_o(irq0)
`endif
  );

  roi_apb_multi #(.ROI_NUM(4), .COORD_W(10), .WAIT_ST(3)) dut3 (
    .clk_i(clk), .arst_i(rst), .apb(bus3), .frame_start_i(frame),
    .roi_en_o(en3), .roi_x0_o(x0_3), .roi_y0_o(y0_3), .roi_x1_o(x1_3), .roi_y1_o(y1_3),
    .commit_done_o(cd3)
`ifdef ROI_IRQ_EN
    , .irq_o(irq3)
`endif
  );

  always #5 clk = ~clk;

  // One APB transfer; n counts access cycles up to and including the ready one.
  task automatic apb(input logic d3, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output int n);
    @(negedge clk);
    use3 = d3; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    penable = 1'b1; n = 1; #1;
    while (cur_pready !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    rd = cur_prdata; err = cur_pslverr;
    nvec++;
    if (cur_pready !== 1'b1) begin errs++; $display("FAIL apb_timeout addr %h: no pready after %0d cycles", a, n); end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk); frame = 1'b1;
    @(negedge clk); frame = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int n;
    nvec++; if (en0 !== 4'h0 || x0_0 !== 40'h0 || y1_0 !== 40'h0 || cd0 !== 1'b0) begin
      errs++; $display("FAIL reset_outputs: en %h x0 %h y1 %h cd %b, want all 0", en0, x0_0, y1_0, cd0); end
    nvec++; if (bus0.pready !== 1'b0 || bus0.pslverr !== 1'b0 || bus0.prdata !== 32'h0) begin
      errs++; $display("FAIL reset_bus: pready %b pslverr %b prdata %h, want 0", bus0.pready, bus0.pslverr, bus0.prdata); end
    @(negedge clk); rst = 1'b0;
    apb(0, 0, 12'h004, 0, rd, err, n);
    nvec++; if (rd !== 32'h0 || err !== 1'b0) begin errs++; $display("FAIL reset_status: got %h err %b, want 0 err 0", rd, err); end
    nvec++; if (n !== 1) begin errs++; $display("FAIL zero_wait: access cycles %0d, want 1", n); end
    apb(0, 0, 12'h008, 0, rd, err, n);
    nvec++; if (rd !== 32'h0 || err !== 1'b1) begin errs++; $display("FAIL unmapped_read: got %h err %b, want 0 err 1", rd, err); end
  endtask

  task automatic test_commit();
    logic [31:0] rd; logic err; int n;
    apb(0, 1, 12'h010, 32'h0190_012C, rd, err, n);
    apb(0, 1, 12'h014, 32'h0258_0190, rd, err, n);
    apb(0, 1, 12'h000, 32'h0000_0101, rd, err, n);
    nvec++; if (err !== 1'b0) begin errs++; $display("FAIL ctrl_write_err: got %b, want 0", err); end
    apb(0, 0, 12'h000, 0, rd, err, n);
    nvec++; if (rd !== 32'h101) begin errs++; $display("FAIL ctrl_read: got %h, want 00000101", rd); end
    nvec++; if (en0 !== 4'h0 || x0_0 !== 40'h0) begin errs++; $display("FAIL pre_commit: en %h x0 %h, want 0", en0, x0_0); end
    pulse_frame();
    nvec++; if (cd0 !== 1'b1) begin errs++; $display("FAIL commit_done_high: got %b, want 1", cd0); end
    nvec++; if (x0_0 !== 40'd400 || y0_0 !== 40'd300 || x1_0 !== 40'd600 || y1_0 !== 40'd400 || en0 !== 4'b0001) begin
      errs++; $display("FAIL roi0_active: x0 %0d y0 %0d x1 %0d y1 %0d en %b, want 400 300 600 400 0001", x0_0, y0_0, x1_0, y1_0, en0); end
    @(negedge clk);
    nvec++; if (cd0 !== 1'b0) begin errs++; $display("FAIL commit_done_pulse: got %b, want 0", cd0); end
`ifdef ROI_IRQ_EN
    nvec++; if (irq0 !== 1'b1) begin errs++; $display("FAIL irq_set: got %b, want 1", irq0); end
`endif
    apb(0, 0, 12'h004, 0, rd, err, n);
    nvec++; if (rd !== C_IRQ) begin errs++; $display("FAIL status_after_commit: got %h, want %h", rd, C_IRQ); end
    apb(0, 1, 12'h004, 32'h4, rd, err, n);
    nvec++; if (err !== 1'b0) begin errs++; $display("FAIL status_bit2_write: err %b, want 0", err); end
  endtask

  task automatic test_pending_err();
    logic [31:0] rd; logic err; int n;
    apb(0, 1, 12'h000, 32'h0000_0101, rd, err, n);
    apb(0, 1, 12'h010, 32'h0005_0005, rd, err, n);
    nvec++; if (err !== 1'b1) begin errs++; $display("FAIL pending_xy_err: got %b, want 1", err); end
    apb(0, 0, 12'h010, 0, rd, err, n);
    nvec++; if (rd !== 32'h0190_012C) begin errs++; $display("FAIL pending_readback: got %h, want 0190012c", rd); end
    apb(0, 1, 12'h004, 32'h1, rd, err, n);
    nvec++; if (err !== 1'b1) begin errs++; $display("FAIL status_bit0_write: err %b, want 1", err); end
    pulse_frame();
    nvec++; if (x0_0 !== 40'd400 || en0 !== 4'b0001) begin errs++; $display("FAIL pending_commit: x0 %0d en %b, want 400 0001", x0_0, en0); end
  endtask

  task automatic test_invalid();
    logic [31:0] rd; logic err; int n;
    apb(0, 1, 12'h018, 32'h0258_00C8, rd, err, n);
    apb(0, 1, 12'h01C, 32'h0190_0190, rd, err, n);
    apb(0, 1, 12'h000, 32'h0000_0301, rd, err, n);
    pulse_frame();
    nvec++; if (en0 !== 4'b0001) begin errs++; $display("FAIL invalid_en: got %b, want 0001", en0); end
    nvec++; if (x0_0 !== ((40'd600 << 10) | 40'd400)) begin errs++; $display("FAIL invalid_coords_copied: x0 %h", x0_0); end
    apb(0, 0, 12'h004, 0, rd, err, n);
    nvec++; if (rd !== (32'h2 | C_IRQ)) begin errs++; $display("FAIL err_set: status %h, want %h", rd, 32'h2 | C_IRQ); end
    apb(0, 1, 12'h004, 32'h6, rd, err, n);
    apb(0, 0, 12'h004, 0, rd, err, n);
    nvec++; if (rd !== 32'h0) begin errs++; $display("FAIL err_w1c: status %h, want 0", rd); end
  endtask

  task automatic test_wait();
    logic [31:0] rd; logic err; int n;
    apb(1, 1, 12'h010, 32'h0005_0006, rd, err, n);
    nvec++; if (n !== 4 || err !== 1'b0) begin errs++; $display("FAIL wait3_write: cycles %0d err %b, want 4 0", n, err); end
    apb(1, 0, 12'h7FC, 0, rd, err, n);
    nvec++; if (n !== 4 || rd !== 32'h0 || err !== 1'b1) begin
      errs++; $display("FAIL wait3_unmapped: cycles %0d rd %h err %b, want 4 0 1", n, rd, err); end
    // abandon a write mid-wait; the shadow must keep its value
    @(negedge clk); use3 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0009_0009;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb(1, 0, 12'h010, 0, rd, err, n);
    nvec++; if (rd !== 32'h0005_0006 || n !== 4) begin errs++; $display("FAIL psel_drop: got %h cycles %0d, want 00050006 4", rd, n); end
    apb(1, 1, 12'h014, 32'h0007_0008, rd, err, n);
    apb(1, 1, 12'h000, 32'h0000_0101, rd, err, n);
    pulse_frame();
    nvec++; if (x0_3 !== 40'd5 || y1_3 !== 40'd8 || en3 !== 4'b0001 || cd3 !== 1'b1) begin
      errs++; $display("FAIL wait3_commit: x0 %0d y1 %0d en %b cd %b, want 5 8 0001 1", x0_3, y1_3, en3, cd3); end
  endtask

  task automatic test_coincident();
    logic [31:0] rd; logic err; int n;
    apb(0, 1, 12'h020, 32'h0001_0002, rd, err, n);
    apb(0, 1, 12'h024, 32'h0003_0004, rd, err, n);
    @(negedge clk); use3 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h701;
    @(negedge clk); penable = 1'b1; frame = 1'b1; #1;
    nvec++; if (bus0.pready !== 1'b1 || bus0.pslverr !== 1'b0) begin
      errs++; $display("FAIL coinc_xfer: pready %b pslverr %b, want 1 0", bus0.pready, bus0.pslverr); end
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0; frame = 1'b0;
    nvec++; if (en0 !== 4'b0001 || cd0 !== 1'b0 || x0_0 !== ((40'd600 << 10) | 40'd400)) begin
      errs++; $display("FAIL coinc_no_apply: en %b cd %b x0 %h", en0, cd0, x0_0); end
    apb(0, 0, 12'h004, 0, rd, err, n);
    nvec++; if (rd !== 32'h1) begin errs++; $display("FAIL coinc_pending: status %h, want 1", rd); end
    pulse_frame();
    nvec++; if (en0 !== 4'b0101 || cd0 !== 1'b1 || x0_0 !== ((40'd1 << 20) | (40'd600 << 10) | 40'd400)) begin
      errs++; $display("FAIL coinc_apply: en %b cd %b x0 %h, want 0101 1", en0, cd0, x0_0); end
    apb(0, 0, 12'h004, 0, rd, err, n);
    nvec++; if (rd !== (32'h2 | C_IRQ)) begin errs++; $display("FAIL coinc_err: status %h, want %h", rd, 32'h2 | C_IRQ); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic err; int n;
    @(negedge clk); use3 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0009_0009;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    nvec++; if (x0_3 !== 40'h0 || en3 !== 4'h0 || cd3 !== 1'b0 || bus3.pready !== 1'b0 || bus3.pslverr !== 1'b0 || bus3.prdata !== 32'h0) begin
      errs++; $display("FAIL arst_dut3: x0 %h en %b pready %b", x0_3, en3, bus3.pready); end
    nvec++; if (x0_0 !== 40'h0 || en0 !== 4'h0) begin errs++; $display("FAIL arst_dut0: x0 %h en %b, want 0", x0_0, en0); end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk); rst = 1'b0;
    apb(1, 0, 12'h010, 0, rd, err, n);
    nvec++; if (rd !== 32'h0) begin errs++; $display("FAIL arst_shadow: got %h, want 0", rd); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_commit();
    test_pending_err();
    test_invalid();
    test_wait();
    test_coincident();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
`default_nettype wire
